// File: rtl/eth10_manchester_tx_pkg.sv
// Shared constants and FSM encoding for the 10BASE-T Manchester transmitter.
package eth10_manchester_tx_pkg;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SFD   = 3'd2,
    ST_DATA  = 3'd3,
    ST_PAD   = 3'd4,
    ST_FCS   = 3'd5,
    ST_TPIDL = 3'd6,
    ST_IFG   = 3'd7
  } state_t;
endpackage

// File: rtl/eth10_manchester_tx_crc32.sv
// Bit-serial reflected CRC-32; advances one bit per enabled cycle, result visible next cycle.
import eth10_manchester_tx_pkg::*;

module eth10_manchester_tx_crc32 (
  input  logic        i_clk20,
  input  logic        i_reset,
  input  logic        i_init,
  input  logic        i_en,
  input  logic        i_din,
  output logic [31:0] o_crc
);
  logic [31:0] r_crc;
  logic        w_fb;

  assign w_fb = r_crc[0] ^ i_din;

  always_ff @(posedge i_clk20) begin
    if (i_reset || i_init) begin
      r_crc <= CRC_INIT;
    end else if (i_en) begin
      r_crc <= {1'b0, r_crc[31:1]} ^ (w_fb ? CRC_POLY_REFL : 32'h0);
    end
  end

  assign o_crc = r_crc;
endmodule

// File: rtl/eth10_manchester_tx.sv
// 10BASE-T frame transmitter: preamble/SFD, payload, zero pad, FCS, TP_IDL, IFG, idle NLPs.
// Pins are registered (one cycle after state); upstream stalls via o_tx_ready on a one-byte holding register.
import eth10_manchester_tx_pkg::*;

module eth10_manchester_tx #(
  parameter int NLP_PERIOD   = 262144,
  parameter int NLP_WIDTH    = 2,
  parameter int IFG_CYCLES   = 192,
  parameter int TPIDL_CYCLES = 5,
  parameter int MIN_PAYLOAD  = 60
) (
  input  logic       i_clk20,
  input  logic       i_reset,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  input  logic       i_tx_last,
  output logic       o_tx_ready,
  output logic       o_tx_busy,
  output logic       o_tx_underrun,
  output logic       o_ethernet_tdp,
  output logic       o_ethernet_tdm
);
  localparam int                NW        = $clog2(NLP_PERIOD);
  localparam logic [NW-1:0]     NLP_MAX   = NW'(NLP_PERIOD - 1);
  localparam logic [7:0]        NLP_HOLD  = 8'(NLP_WIDTH - 1);
  localparam logic [7:0]        TPIDL_MAX = 8'(TPIDL_CYCLES - 1);
  localparam logic [7:0]        IFG_MAX   = 8'(IFG_CYCLES - 1);
  localparam logic [5:0]        MIN_CNT   = 6'(MIN_PAYLOAD);

  state_t        r_state, w_next;
  logic [3:0]    r_cyc;
  logic [5:0]    r_cnt;
  logic [7:0]    r_shift, r_hold, r_tmr, r_nlp_left;
  logic          r_hold_full, r_hold_last, r_cur_last, r_last_seen;
  logic [NW-1:0] r_nlp_tmr;
  logic          r_tdp, r_tdm, r_underrun;
  logic [31:0]   w_crc;
  logic [5:0]    w_cnt_inc;
  logic          w_in_frame, w_loading, w_boundary, w_ready, w_acc, w_bypass, w_abort;
  logic          w_nlp_due, w_bit, w_tdp, w_tdm;

  assign w_in_frame = (r_state == ST_PRE) || (r_state == ST_SFD) || (r_state == ST_DATA) ||
                      (r_state == ST_PAD) || (r_state == ST_FCS);
  assign w_loading  = (r_state == ST_PRE) || (r_state == ST_SFD) || (r_state == ST_DATA);
  assign w_boundary = w_in_frame && (r_cyc == 4'hF);
  assign w_ready    = !i_reset && (((r_state == ST_IDLE) && (r_nlp_left == 8'd0)) ||
                      (w_loading && !r_hold_full && !r_last_seen));
  assign w_acc      = i_tx_valid && w_ready;
  // A byte arriving exactly on an empty-holding boundary goes straight to the shifter.
  assign w_bypass   = (r_state == ST_DATA) && w_boundary && !r_hold_full && w_acc;
  assign w_abort    = (r_state == ST_DATA) && w_boundary && !r_cur_last && !r_hold_full && !w_acc;
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + 6'd1;
  assign w_nlp_due  = (r_state == ST_IDLE) && (r_nlp_tmr == NLP_MAX) && !w_acc;

  eth10_manchester_tx_crc32 u_crc (
    .i_clk20 (i_clk20),
    .i_reset (i_reset),
    .i_init  ((r_state == ST_IDLE) || (r_state == ST_PRE)),
    .i_en    (((r_state == ST_DATA) || (r_state == ST_PAD)) && r_cyc[0]),
    .i_din   (r_shift[0]),
    .o_crc   (w_crc)
  );

  always_ff @(posedge i_clk20) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_acc) w_next = ST_PRE;
      ST_PRE:   if (w_boundary && (r_cnt == 6'd6)) w_next = ST_SFD;
      ST_SFD:   if (w_boundary) w_next = ST_DATA;
      ST_DATA:  if (w_boundary) begin
                  if (r_cur_last)   w_next = (w_cnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
                  else if (w_abort) w_next = ST_TPIDL;
                end
      ST_PAD:   if (w_boundary && (w_cnt_inc >= MIN_CNT)) w_next = ST_FCS;
      ST_FCS:   if (w_boundary && (r_cnt == 6'd3)) w_next = ST_TPIDL;
      ST_TPIDL: if (r_tmr == TPIDL_MAX) w_next = ST_IFG;
      ST_IFG:   if (r_tmr == IFG_MAX) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk20) begin
    if (i_reset) begin
      r_cyc <= '0; r_cnt <= '0; r_shift <= '0; r_hold <= '0; r_tmr <= '0;
      r_hold_full <= 1'b0; r_hold_last <= 1'b0; r_cur_last <= 1'b0; r_last_seen <= 1'b0;
      r_nlp_tmr <= '0; r_nlp_left <= '0; r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_abort;
      r_cyc      <= w_in_frame ? r_cyc + 4'd1 : 4'd0;
      r_tmr      <= ((r_state == ST_TPIDL || r_state == ST_IFG) && r_state == w_next) ?
                    r_tmr + 8'd1 : 8'd0;
      if (w_acc && !w_bypass) begin
        r_hold <= i_tx_data; r_hold_full <= 1'b1; r_hold_last <= i_tx_last;
      end
      if (w_acc && i_tx_last) r_last_seen <= 1'b1;
      if (w_in_frame && r_cyc[0] && !w_boundary) r_shift <= {1'b0, r_shift[7:1]};
      if (w_boundary) begin
        case (r_state)
          ST_PRE: begin
            r_shift <= (r_cnt == 6'd6) ? SFD_BYTE : PREAMBLE_BYTE;
            r_cnt   <= (r_cnt == 6'd6) ? 6'd0 : r_cnt + 6'd1;
          end
          ST_SFD: begin
            r_shift <= r_hold; r_cur_last <= r_hold_last; r_hold_full <= 1'b0; r_cnt <= '0;
          end
          ST_DATA: begin
            r_cnt <= w_cnt_inc;
            if (r_cur_last) begin
              r_shift <= '0;
              if (w_cnt_inc >= MIN_CNT) r_cnt <= '0;
            end else if (r_hold_full) begin
              r_shift <= r_hold; r_cur_last <= r_hold_last; r_hold_full <= 1'b0;
            end else if (w_acc) begin
              r_shift <= i_tx_data; r_cur_last <= i_tx_last;
            end
          end
          ST_PAD: begin
            r_shift <= '0;
            r_cnt   <= (w_cnt_inc >= MIN_CNT) ? 6'd0 : w_cnt_inc;
          end
          default: r_cnt <= r_cnt + 6'd1;
        endcase
      end
      if (r_state == ST_IDLE) begin
        if (w_acc) begin
          r_shift <= PREAMBLE_BYTE; r_cnt <= '0; r_cur_last <= 1'b0; r_last_seen <= i_tx_last;
          r_nlp_tmr <= '0; r_nlp_left <= '0;
        end else begin
          r_nlp_tmr <= (r_nlp_tmr == NLP_MAX) ? '0 : r_nlp_tmr + 1'b1;
          if (w_nlp_due)               r_nlp_left <= NLP_HOLD;
          else if (r_nlp_left != 8'd0) r_nlp_left <= r_nlp_left - 8'd1;
        end
      end else begin
        r_nlp_tmr <= '0; r_nlp_left <= '0;
      end
    end
  end

  // FCS streams straight out of the frozen CRC register, complemented, bit 0 first.
  assign w_bit = (r_state == ST_FCS) ? ~w_crc[{r_cnt[1:0], r_cyc[3:1]}] : r_shift[0];

  always_comb begin
    w_tdp = 1'b0;
    w_tdm = 1'b0;
    if (w_in_frame) begin
      w_tdp = r_cyc[0] ? w_bit : ~w_bit;
      w_tdm = ~w_tdp;
    end else if (r_state == ST_TPIDL) begin
      w_tdp = 1'b1;
    end else if (r_state == ST_IDLE) begin
      w_tdp = w_nlp_due || (r_nlp_left != 8'd0);
    end
  end

  always_ff @(posedge i_clk20) begin
    if (i_reset) begin
      r_tdp <= 1'b0; r_tdm <= 1'b0;
    end else begin
      r_tdp <= w_tdp; r_tdm <= w_tdm;
    end
  end

  assign o_tx_ready     = w_ready;
  assign o_tx_busy      = (r_state != ST_IDLE);
  assign o_tx_underrun  = r_underrun;
  assign o_ethernet_tdp = r_tdp;
  assign o_ethernet_tdm = r_tdm;
endmodule

// File: tb/tb_eth10_manchester_tx.sv
// Directed bench: decodes the Manchester wire and checks it against a CRC reference model.
module tb_eth10_manchester_tx;
  import eth10_manchester_tx_pkg::*;

  localparam int NLP_P   = 100;
  localparam int TPIDL_C = 5;
  localparam int IFG_C   = 192;

  logic       clk = 1'b0, reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0, tx_last = 1'b0;
  logic       tx_ready, tx_busy, tx_underrun, tdp, tdm;

  always #5 clk = ~clk;

  eth10_manchester_tx #(.NLP_PERIOD(NLP_P)) dut (
    .i_clk20(clk), .i_reset(reset), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
    .i_tx_last(tx_last), .o_tx_ready(tx_ready), .o_tx_busy(tx_busy),
    .o_tx_underrun(tx_underrun), .o_ethernet_tdp(tdp), .o_ethernet_tdm(tdm)
  );

  typedef struct {
    int         len;
    int         stop_at;
    logic [7:0] mul;
    logic [7:0] add;
    int         exp_bytes;
    int         exp_under;
  } vec_t;

  int         errors = 0, checks = 0;
  bit         rec = 1'b0;
  bit         q_p[$], q_m[$], q_b[$], q_r[$], q_u[$];
  logic [7:0] dec[$];
  logic [7:0] pl[0:127];
  vec_t       vecs[6];

  always @(negedge clk) begin
    if (rec) begin
      q_p.push_back(tdp); q_m.push_back(tdm); q_b.push_back(tx_busy);
      q_r.push_back(tx_ready); q_u.push_back(tx_underrun);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Returns the index of the first pin sample after the last valid Manchester bit.
  function automatic int decode();
    int s, j, nb;
    logic [7:0] cur;
    s = -1; nb = 0; cur = 8'h00;
    dec.delete();
    for (int i = 0; i < q_p.size(); i++) begin
      if (q_m[i] && s < 0) s = i;
    end
    if (s < 0) return 0;
    j = s;
    while (j + 1 < q_p.size() && q_m[j] == !q_p[j] && q_m[j+1] == !q_p[j+1] && q_p[j] != q_p[j+1]) begin
      cur = {q_p[j+1], cur[7:1]};
      nb++;
      if (nb == 8) begin dec.push_back(cur); nb = 0; end
      j += 2;
    end
    return j;
  endfunction

  task automatic clear_q();
    q_p.delete(); q_m.delete(); q_b.delete(); q_r.delete(); q_u.delete();
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic feed(input int n, input int stop_at);
    int i, cyc;
    bit acc;
    i = 0; cyc = 0;
    while (i < n && i < stop_at && cyc < 4000) begin
      @(negedge clk);
      tx_valid = 1'b1; tx_data = pl[i]; tx_last = (i == n - 1);
      #1 acc = tx_ready;
      @(posedge clk);
      if (acc) i++;
      cyc++;
    end
    @(negedge clk);
    tx_valid = 1'b0; tx_last = 1'b0;
    chk("feed_timeout", (cyc < 4000), 1);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (!tx_busy) break;
    end
    chk("idle_timeout", tx_busy, 0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0]  exp_q[$];
    logic [31:0] c;
    int k, n, mism, run, idle_i, rdy_i, ucnt, uidx;
    for (int i = 0; i < v.len; i++) pl[i] = 8'(i * v.mul + v.add);
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    n = (v.exp_under != 0) ? v.stop_at : v.len;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin exp_q.push_back(pl[i]); c = crc_byte(c, pl[i]); end
    if (v.exp_under == 0) begin
      for (int i = n; i < 60; i++) begin exp_q.push_back(8'h00); c = crc_byte(c, 8'h00); end
      for (int i = 0; i < 4; i++) exp_q.push_back(~c[8*i +: 8]);
    end
    clear_q();
    @(posedge clk); rec = 1'b1;
    feed(v.len, v.stop_at);
    wait_idle();
    repeat (3) @(negedge clk);
    rec = 1'b0;
    k = decode();
    chk($sformatf("wire_len_len%0d", v.len), dec.size(), v.exp_bytes);
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= dec.size()) mism++;
      else if (dec[i] !== exp_q[i]) mism++;
    end
    chk($sformatf("wire_bytes_len%0d", v.len), mism, 0);
    if (v.exp_under == 0 && dec.size() > 8) begin
      c = 32'hFFFFFFFF;
      for (int i = 8; i < dec.size(); i++) c = crc_byte(c, dec[i]);
      chk($sformatf("residue_len%0d", v.len), c, CRC_RESIDUE);
    end
    run = 0;
    for (int i = k; i < q_p.size() && q_p[i] && !q_m[i]; i++) run++;
    chk($sformatf("tpidl_len%0d", v.len), run, TPIDL_C);
    idle_i = -1; rdy_i = -1; ucnt = 0; uidx = -1;
    for (int i = 0; i < q_u.size(); i++) if (q_u[i]) begin ucnt++; uidx = i; end
    for (int i = q_b.size() - 1; i >= k; i--) if (!q_b[i]) idle_i = i;
    for (int i = q_r.size() - 1; i >= k; i--) if (q_r[i]) rdy_i = i;
    // Pins trail state by one cycle, so busy ends TPIDL+IFG-1 samples after TP_IDL appears.
    chk($sformatf("gap_len%0d", v.len), idle_i - k, TPIDL_C + IFG_C - 1);
    chk($sformatf("ready_back_len%0d", v.len), rdy_i, idle_i);
    chk($sformatf("underrun_cnt_len%0d", v.len), ucnt, v.exp_under);
    if (v.exp_under != 0) chk("underrun_idx", uidx, k - 1);
  endtask

  initial begin
    int hp[$];
    int tdm_bad;
    vecs[0] = '{64, 64, 8'h01, 8'h00, 76, 0};
    vecs[1] = '{ 1,  1, 8'h00, 8'hAB, 72, 0};
    vecs[2] = '{64, 11, 8'h01, 8'h00, 19, 1};
    vecs[3] = '{60, 60, 8'h03, 8'h11, 72, 0};
    vecs[4] = '{59, 59, 8'h07, 8'h05, 72, 0};
    vecs[5] = '{61, 61, 8'h1D, 8'h80, 73, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", tx_ready, 0); chk("rst_busy", tx_busy, 0);
    chk("rst_tdp", tdp, 0); chk("rst_tdm", tdm, 0); chk("rst_underrun", tx_underrun, 0);
    reset = 1'b0;
    #1 chk("ready_after_rst", tx_ready, 1);

    // Idle link pulses: period NLP_P, two cycles wide, TDm never driven.
    clear_q();
    @(posedge clk); rec = 1'b1;
    repeat (3 * NLP_P + 10) @(negedge clk);
    rec = 1'b0;
    tdm_bad = 0;
    for (int i = 0; i < q_p.size(); i++) begin
      if (q_p[i]) hp.push_back(i);
      if (q_m[i]) tdm_bad++;
    end
    chk("nlp_count", hp.size(), 6);
    for (int i = 0; i < 6 && i < hp.size(); i++)
      chk($sformatf("nlp_pos%0d", i), hp[i], (i / 2 + 1) * NLP_P - 1 + (i % 2));
    chk("nlp_tdm", tdm_bad, 0);
    chk("nlp_ready_due", q_r[NLP_P-2], 1);
    chk("nlp_ready_pulse", q_r[NLP_P-1], 0);

    // Accept on the NLP-due cycle: frame wins, no pulse.
    do_reset();
    @(posedge clk);
    repeat (NLP_P - 1) @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'hAB; tx_last = 1'b1;
    #1 chk("due_ready", tx_ready, 1);
    @(negedge clk);
    tx_valid = 1'b0; tx_last = 1'b0;
    chk("due_no_nlp", {tdp, tdm}, 2'b00);
    chk("due_busy", tx_busy, 1);
    chk("ready_after_last", tx_ready, 0);
    @(negedge clk);
    chk("first_halfbit", {tdp, tdm}, 2'b01);
    wait_idle();

    // Request during the pulse waits for the pulse to end.
    do_reset();
    @(posedge clk);
    repeat (NLP_P) @(negedge clk);
    chk("mid_pulse_tdp", tdp, 1);
    chk("mid_pulse_ready", tx_ready, 0);
    tx_valid = 1'b1; tx_data = 8'h11; tx_last = 1'b1;
    @(negedge clk);
    chk("mid_pulse_not_acc", tx_busy, 0);
    chk("post_pulse_ready", tx_ready, 1);
    @(negedge clk);
    tx_valid = 1'b0; tx_last = 1'b0;
    chk("post_pulse_acc", tx_busy, 1);
    wait_idle();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset while the FCS is on the wire, then a clean frame.
    pl[0] = 8'h3C;
    feed(1, 1);
    repeat (1100) @(negedge clk);
    chk("fcs_busy", tx_busy, 1);
    chk("fcs_active", tdm, !tdp);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_pins", {tdp, tdm}, 2'b00);
    chk("rst_mid_busy", tx_busy, 0);
    chk("rst_mid_ready", tx_ready, 0);
    reset = 1'b0;
    run_vec('{1, 1, 8'h00, 8'h5A, 72, 0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
